// File: rtl/abm_ram_streamer.sv
// Streams consecutive ABM RAM rows out as AXI4-Stream beats.
// A credit-limited output FIFO absorbs RAM read latency so backpressure never drops data.
module abm_ram_streamer #(
  parameter int unsigned DW          = 512,
  parameter int unsigned DD          = 16384,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = RAM_LATENCY + 2,
  parameter int unsigned AW          = $clog2(DD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   beat_count,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] dob,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic          M_AXIS_TVALID,
  output logic          M_AXIS_TLAST,
  input  logic          M_AXIS_TREADY
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [AW:0] ONE_BEAT = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW:0]   left_q, left_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] addrb_q, addrb_d;

  // Stage 0 is the addrb register; stage RAM_LATENCY lines up with valid dob.
  logic [RAM_LATENCY:0] tok_vld_q, tok_last_q;
  logic [CW-1:0]        inflight_q;

  logic [DW-1:0] mem_q      [FIFO_DEPTH];
  logic          last_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  logic issue, issue_last, cap, pop, tvalid, credit_ok;

  assign tvalid    = (cnt_q != '0);
  assign pop       = tvalid & M_AXIS_TREADY;
  assign cap       = tok_vld_q[RAM_LATENCY];
  // A beat leaving this cycle frees its slot for a read issued this cycle.
  assign credit_ok = (inflight_q + cnt_q - CW'(pop)) < CW'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    left_d     = left_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    addrb_d    = addrb_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          if (beat_count == '0) begin
            done_d = 1'b1;
          end else begin
            row_d   = start_addr;
            left_d  = beat_count;
            busy_d  = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (left_q == ONE_BEAT);
          addrb_d    = row_q;
          row_d      = (row_q == AW'(DD - 1)) ? '0 : row_q + 1'b1;
          left_d     = left_q - 1'b1;
          if (left_q == ONE_BEAT) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0 && inflight_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      left_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addrb_q    <= '0;
      tok_vld_q  <= '0;
      tok_last_q <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      left_q     <= left_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addrb_q    <= addrb_d;
      tok_vld_q  <= {tok_vld_q[RAM_LATENCY-1:0], issue};
      tok_last_q <= {tok_last_q[RAM_LATENCY-1:0], issue_last};
      inflight_q <= inflight_q + CW'(issue) - CW'(cap);
      cnt_q      <= cnt_q + CW'(cap) - CW'(pop);
      if (cap) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      mem_q[wr_ptr_q]      <= dob;
      last_mem_q[wr_ptr_q] <= tok_last_q[RAM_LATENCY];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(cap && !pop && cnt_q == CW'(FIFO_DEPTH)));

  assign busy          = busy_q;
  assign done          = done_q;
  assign addrb         = addrb_q;
  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TDATA  = mem_q[rd_ptr_q];
  assign M_AXIS_TLAST  = tvalid & last_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_abm_ram_streamer.sv
// Scoreboard bench for abm_ram_streamer: directed transfers against a RAM model where row i holds i.
module tb_abm_ram_streamer;
  localparam int unsigned DW = 64;
  localparam int unsigned DD = 16384;
  localparam int unsigned L  = 2;
  localparam int unsigned FD = L + 2;
  localparam int unsigned AW = $clog2(DD);

  logic          clk = 1'b0;
  logic          reset, start, tready;
  logic [AW-1:0] start_addr, addrb;
  logic [AW:0]   beat_count;
  logic          busy, done, tvalid, tlast;
  logic [DW-1:0] dob, tdata;

  always #5 clk = ~clk;

  abm_ram_streamer #(.DW(DW), .DD(DD), .RAM_LATENCY(L), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .beat_count(beat_count), .busy(busy), .done(done), .addrb(addrb), .dob(dob),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready)
  );

  // RAM model: dob reflects the row addressed L cycles earlier.
  logic [AW-1:0] rpipe [L];
  always @(posedge clk) begin
    rpipe[0] <= addrb;
    for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
  end
  assign dob = DW'(rpipe[L-1]);

  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
  beat_t expq[$];
  beat_t e;
  int n_cmp = 0, n_err = 0, n_pop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_d;
  logic          stall_l;
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_tvalid", 64'(tvalid), 64'd1);
        chk("stall_tdata", tdata, stall_d);
        chk("stall_tlast", 64'(tlast), 64'(stall_l));
      end
      if (tvalid && tready) begin
        if (expq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat", tdata);
        end else begin
          e = expq.pop_front();
          chk("beat_tdata", tdata, e.d);
          chk("beat_tlast", 64'(tlast), 64'(e.l));
        end
        n_pop++;
      end
      stall_q = tvalid && !tready;
      stall_d = tdata;
      stall_l = tlast;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int unsigned a, input int unsigned c);
    start = 1'b1; start_addr = AW'(a); beat_count = (AW+1)'(c);
    for (int unsigned i = 0; i < c; i++)
      expq.push_back('{d: DW'((a + i) % DD), l: (i == c - 1)});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    logic found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (done) begin found = 1'b1; break; end
    end
    chk(nm, 64'(found), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] prev;
    int changes, base;
    logic seen;
    reset = 1'b1; start = 1'b0; start_addr = '0; beat_count = '0; tready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_addrb", 64'(addrb), 0);
    chk("rst_tvalid", 64'(tvalid), 0);
    chk("rst_tlast", 64'(tlast), 0);
    reset = 1'b0;
    tick();

    // Basic 4-beat transfer with exact latency and done timing.
    tready = 1'b1;
    do_start(5, 4);
    chk("t1_busy", 64'(busy), 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_tvalid_early", 64'(tvalid), 0);
    end
    tick();
    chk("t1_first_tvalid", 64'(tvalid), 1);
    repeat (4) tick();
    chk("t1_tvalid_after", 64'(tvalid), 0);
    chk("t1_done_early", 64'(done), 0);
    chk("t1_busy_drain", 64'(busy), 1);
    tick();
    chk("t1_done", 64'(done), 1);
    chk("t1_busy_clear", 64'(busy), 0);
    tick();
    chk("t1_done_pulse", 64'(done), 0);
    chk("t1_q_empty", 64'(expq.size()), 0);

    // Same transfer under ~30% TREADY duty.
    do_start(5, 4);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tready = ($urandom_range(0, 9) < 3);
      tick();
      if (done) begin seen = 1'b1; break; end
    end
    chk("t2_done", 64'(seen), 1);
    chk("t2_q_empty", 64'(expq.size()), 0);
    tready = 1'b0;
    tick();

    // Long stall: only FIFO_DEPTH reads may be issued.
    prev = addrb;
    changes = 0;
    do_start(100, 16);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (addrb != prev) changes++;
      prev = addrb;
    end
    chk("t3_reads_issued", 64'(changes), 64'(FD));
    chk("t3_addrb_frozen", 64'(addrb), 64'(100 + FD - 1));
    chk("t3_tvalid_held", 64'(tvalid), 1);
    tready = 1'b1;
    wait_done(100, "t3_done");
    chk("t3_q_empty", 64'(expq.size()), 0);
    tick();

    // Address wrap at the top of the RAM.
    do_start(16382, 4);
    wait_done(50, "t4_done");
    chk("t4_q_empty", 64'(expq.size()), 0);
    tick();

    // Zero-length transfer.
    do_start(7, 0);
    chk("t5_zero_done", 64'(done), 1);
    chk("t5_zero_busy", 64'(busy), 0);
    chk("t5_zero_tvalid", 64'(tvalid), 0);
    tick();
    chk("t5_zero_done_pulse", 64'(done), 0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (busy || tvalid || done) seen = 1'b1;
    end
    chk("t5_zero_quiet", 64'(seen), 0);

    // Start while busy is ignored; start coincident with done is ignored.
    do_start(20, 3);
    tick();
    start = 1'b1; start_addr = AW'(50); beat_count = (AW+1)'(5);
    tick();
    start = 1'b0;
    wait_done(50, "t5_busy_done");
    start = 1'b1; start_addr = AW'(60); beat_count = (AW+1)'(2);
    tick();
    start = 1'b0;
    chk("t5_start_on_done_busy", 64'(busy), 0);
    repeat (8) tick();
    chk("t5_start_on_done_tvalid", 64'(tvalid), 0);
    chk("t5_q_empty", 64'(expq.size()), 0);

    // Reset mid-transfer, then a fresh 2-beat transfer.
    do_start(200, 10);
    base = n_pop;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (n_pop - base >= 3) begin seen = 1'b1; break; end
      tick();
    end
    chk("t6_three_beats", 64'(seen), 1);
    reset = 1'b1;
    tick();
    chk("t6_rst_busy", 64'(busy), 0);
    chk("t6_rst_tvalid", 64'(tvalid), 0);
    chk("t6_rst_done", 64'(done), 0);
    expq.delete();
    reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (done || tvalid) seen = 1'b1;
    end
    chk("t6_no_done_after_abort", 64'(seen), 0);
    do_start(300, 2);
    wait_done(50, "t6_done");
    chk("t6_q_empty", 64'(expq.size()), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
